// File: rtl/scan_pingpong_mc.sv
// ---------------------------------------------------------------------------
// scan_pingpong_mc
// Multi-channel ping-pong scan buffer in the rcv_clk domain. Samples from
// the packet decoder are captured per channel into the write bank between
// scan syncs. A sync commits the captured scan, which is then streamed out
// channel by channel with start/end-of-scan markers. A sync that arrives
// while a readout is still in progress discards the new scan and reports
// a drop.
//
// Ports:
//   rcv_clk, rst_n    clock, asynchronous active-low reset
//   i_sync            single-cycle scan-start pulse
//   i_data/i_ch/i_vld sample input with its channel index
//   o_st_*            output stream (data, channel tag, sop, eop, valid)
//   i_st_rdy          downstream ready
//   o_busy            readout of a committed scan in progress
//   o_drop            one-cycle pulse when a scan is discarded
//   o_drop_cnt        saturating count of discarded scans
// ---------------------------------------------------------------------------
module scan_pingpong_mc #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int CH_NUM     = 2,
    parameter int CH_W       = 1,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  rcv_clk,
    input  logic                  rst_n,
    input  logic                  i_sync,
    input  logic [DATA_W-1:0]     i_data,
    input  logic [CH_W-1:0]       i_ch,
    input  logic                  i_vld,
    output logic [DATA_W-1:0]     o_st_data,
    output logic [CH_W-1:0]       o_st_ch,
    output logic                  o_st_sop,
    output logic                  o_st_eop,
    output logic                  o_st_vld,
    input  logic                  i_st_rdy,
    output logic                  o_busy,
    output logic                  o_drop,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    localparam int NCH = 1 << CH_W;
    localparam int AW  = 1 + CH_W + DEPTH_LOG2;
    localparam int PW  = DEPTH_LOG2 + 1;
    localparam int EW  = DATA_W + CH_W + 2;

    typedef enum logic [1:0] {IDLE, CH_SEL, STREAM} state_t;

    logic [DATA_W-1:0]     mem_q [0:(1<<AW)-1];
    logic [PW-1:0]         wptr_q [0:NCH-1];
    logic [PW-1:0]         len_q  [0:NCH-1];
    logic                  wbank_q, rbank_q;
    logic                  drop_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       c_q, c_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic                  first_q, first_d;

    logic                  rd_vld_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic [CH_W-1:0]       rd_ch_q;
    logic                  rd_sop_q, rd_eop_q;

    logic [EW-1:0]         ent0_q, ent1_q;
    logic [1:0]            cnt_q;

    logic                  busy_int, commit, drop, pop, wr_ok, we, wr_bank;
    logic [PW-1:0]         cur_ptr;
    logic [AW-1:0]         waddr, raddr;
    logic [NCH-1:0]        nz;
    logic [CH_W:0]         sel, nxt;
    logic [CH_W-1:0]       ic;
    logic [DEPTH_LOG2-1:0] iptr;
    logic                  issue, space, last_in_ch, issue_sop, issue_eop;
    logic [1:0]            occ;

    // Lowest non-empty channel at or above 'start'; MSB of the result is
    // the found flag.
    function automatic logic [CH_W:0] findFrom(input logic [NCH-1:0] mask,
                                               input int start);
        logic [CH_W:0] r;
        r = '0;
        for (int j = CH_NUM - 1; j >= 0; j--) begin
            if (j >= start && mask[j]) r = {1'b1, CH_W'(j)};
        end
        return r;
    endfunction

    // The reader counts as busy until every word it issued has left the
    // output buffer, so a sync is only committed once the stream drained.
    assign busy_int = (state_q != IDLE) || rd_vld_q || (cnt_q != 2'd0);
    assign commit   = i_sync && !busy_int;
    assign drop     = i_sync && busy_int;
    assign pop      = (cnt_q != 2'd0) && i_st_rdy;

    // A sample arriving with the sync belongs to the new scan: address 0
    // of the bank that is the write bank after this cycle.
    assign wr_ok   = i_vld && ({1'b0, i_ch} < (CH_W+1)'(CH_NUM));
    assign cur_ptr = i_sync ? '0 : wptr_q[i_ch];
    assign we      = wr_ok && !cur_ptr[PW-1];
    assign wr_bank = commit ? ~wbank_q : wbank_q;
    assign waddr   = {wr_bank, i_ch, cur_ptr[DEPTH_LOG2-1:0]};

    always_comb begin
        nz = '0;
        for (int k = 0; k < CH_NUM; k++) nz[k] = (len_q[k] != '0);
    end

    // Reader next-state. CH_SEL issues the first read itself and STREAM
    // hops straight to the next non-empty channel on its last word, which
    // keeps the stream gap-free across channel boundaries and the first
    // word three cycles after the commit.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        sel       = findFrom(nz, int'(c_q));
        ic        = (state_q == CH_SEL) ? sel[CH_W-1:0] : c_q;
        iptr      = (state_q == CH_SEL) ? '0 : ptr_q;
        nxt       = findFrom(nz, int'(ic) + 1);
        last_in_ch = (({1'b0, iptr} + PW'(1)) == len_q[ic]);
        occ       = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
        space     = (occ < 2'd2);
        // The output buffer is always empty on entry to CH_SEL.
        issue     = ((state_q == CH_SEL) && sel[CH_W]) ||
                    ((state_q == STREAM) && space);
        raddr     = {rbank_q, ic, iptr};
        issue_sop = first_q;
        issue_eop = last_in_ch && !nxt[CH_W];

        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = CH_SEL;
                    c_d     = '0;
                    first_d = 1'b1;
                end
            end
            CH_SEL: begin
                if (!sel[CH_W]) state_d = IDLE;
            end
            default: ;
        endcase

        if (issue) begin
            first_d = 1'b0;
            if (!last_in_ch) begin
                state_d = STREAM;
                c_d     = ic;
                ptr_d   = iptr + DEPTH_LOG2'(1);
            end else if (nxt[CH_W]) begin
                state_d = STREAM;
                c_d     = nxt[CH_W-1:0];
                ptr_d   = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Dual-port storage: write port from the capture side, synchronous
    // read port with one cycle of latency for the reader.
    always_ff @(posedge rcv_clk) begin
        if (we) mem_q[waddr] <= i_data;
        if (issue) rd_data_q <= mem_q[raddr];
    end

    // Capture side: pointers, bank swap, committed lengths, drop status.
    always_ff @(posedge rcv_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                wptr_q[k] <= '0;
                len_q[k]  <= '0;
            end
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_q <= drop;
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            if (i_sync) begin
                for (int k = 0; k < NCH; k++) wptr_q[k] <= '0;
            end
            if (we) wptr_q[i_ch] <= cur_ptr + PW'(1);
            if (commit) begin
                for (int k = 0; k < NCH; k++) len_q[k] <= wptr_q[k];
                rbank_q <= wbank_q;
                wbank_q <= ~wbank_q;
            end
        end
    end

    // Reader state, read pipeline tags and the 2-entry output buffer.
    // ent0_q is always the head; a push lands behind whatever survives
    // this cycle's pop.
    always_ff @(posedge rcv_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_q      <= '0;
            ptr_q    <= '0;
            first_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_ch_q  <= '0;
            rd_sop_q <= 1'b0;
            rd_eop_q <= 1'b0;
            ent0_q   <= '0;
            ent1_q   <= '0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            ptr_q    <= ptr_d;
            first_q  <= first_d;
            rd_vld_q <= issue;
            if (issue) begin
                rd_ch_q  <= ic;
                rd_sop_q <= issue_sop;
                rd_eop_q <= issue_eop;
            end
            if (pop) ent0_q <= ent1_q;
            if (rd_vld_q) begin
                if (cnt_q == {1'b0, pop}) ent0_q <= {rd_sop_q, rd_eop_q, rd_ch_q, rd_data_q};
                else                      ent1_q <= {rd_sop_q, rd_eop_q, rd_ch_q, rd_data_q};
            end
            cnt_q <= cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
        end
    end

    assign o_st_vld = (cnt_q != 2'd0);
    assign {o_st_sop, o_st_eop, o_st_ch, o_st_data} = ent0_q;
    assign o_busy     = busy_int || i_sync;
    assign o_drop     = drop_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule
